// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption engine: one Feistel round per clock, 16 rounds per block,
// with valid/ready handshakes on both sides and one block in flight at a time.
module des_decrypt_iter #(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] ct_in,
  input  logic [1:64] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] pt_out,
  output logic        busy
);

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Tables use DES numbering (bit 1 = MSB); DES bit k of an n-bit word sits at index n-k.
  function automatic logic [63:0] ip(input logic [63:0] x);
    ip = '0;
    for (int i = 0; i < 64; i++) ip[6'(63 - i)] = x[6'(64 - IP_T[i])];
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    fp = '0;
    for (int i = 0; i < 64; i++) fp[6'(63 - i)] = x[6'(64 - FP_T[i])];
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    expand = '0;
    for (int i = 0; i < 48; i++) expand[6'(47 - i)] = x[5'(32 - E_T[i])];
  endfunction

  function automatic logic [31:0] pbox(input logic [31:0] x);
    pbox = '0;
    for (int i = 0; i < 32; i++) pbox[5'(31 - i)] = x[5'(32 - P_T[i])];
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    pc1 = '0;
    for (int i = 0; i < 56; i++) pc1[6'(55 - i)] = x[6'(64 - PC1_T[i])];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    pc2 = '0;
    for (int i = 0; i < 48; i++) pc2[6'(47 - i)] = x[6'(56 - PC2_T[i])];
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] l, r;
  logic [27:0] c, d;
  logic [4:0]  rnd;

  logic [27:0] c_rot, d_rot;
  logic [47:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] f_out, l_new, r_new;
  logic        accept, last;

  assign in_ready = (state == IDLE) && rst_n;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (rnd == 5'd16);

  // Decryption walks the key schedule backwards, so C/D rotate right.
  always_comb begin
    // NOTE: defaults first so every path assigns c_rot/d_rot and no latch is inferred.
    c_rot = c;
    d_rot = d;
    if (rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16) begin
      c_rot = {c[0], c[27:1]};
      d_rot = {d[0], d[27:1]};
    end else if (rnd != 5'd1) begin
      c_rot = {c[1:0], c[27:2]};
      d_rot = {d[1:0], d[27:2]};
    end
  end

  assign sbox_in = expand(r) ^ pc2({c_rot, d_rot});

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    des_sbox #(.SEL(g + 1)) u_sbox (
      .din  (sbox_in[47 - 6*g -: 6]),
      .dout (sbox_out[31 - 4*g -: 4])
    );
  end

  assign f_out = pbox(sbox_out);
  assign l_new = r;
  assign r_new = l ^ f_out;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = ROUND;
      ROUND:   if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      rnd       <= '0;
      pt_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            {l, r} <= ip(ct_in);
            {c, d} <= pc1(key_in);
            rnd    <= 5'd1;
          end
        end
        ROUND: begin
          l <= l_new;
          r <= r_new;
          c <= c_rot;
          d <= d_rot;
          if (last) begin
            pt_out    <= fp({r_new, l_new});
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ZEROIZE) begin
              l <= '0;
              r <= '0;
              c <= '0;
              d <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// DES S-box: 6-bit in, 4-bit out; row = outer bits, column = middle four bits.
module des_sbox #(
  parameter int SEL = 1
) (
  input  logic [5:0] din,
  output logic [3:0] dout
);

  typedef logic [0:63][3:0] table_t;

  function automatic table_t sel_table(input int s);
    case (s)
      1: return 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      2: return 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3: return 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      4: return 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      5: return 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      6: return 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      7: return 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: return 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
  endfunction

  localparam table_t TBL = sel_table(SEL);

  assign dout = TBL[{din[5], din[0], din[4:1]}];

endmodule

// File: doc/des_decrypt_iter.md
Name: des_decrypt_iter

Overview:
- Iterative DES decryption engine: one 64-bit ciphertext block plus one 64-bit key in, one 64-bit plaintext block out.
- Executes one Feistel round per clock; 16 rounds per block.
- Instantiates the team's eight DES S-box modules S1..S8 (6-bit in, 4-bit out, row = bits 1 and 6, column = bits 2..5) inside its round function.
- Sits as the inverse (decrypt) counterpart beside the encryption datapath.
- Valid/ready handshakes on both sides; one block in flight at a time.

Parameters:
- ZEROIZE, default 1: when 1, the L, R, C and D working registers clear to 0 on the DONE->IDLE transition. When 0, they hold their last values.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: ct_in and key_in are valid.
- in_ready, output, 1: engine can accept a block.
- ct_in, input, [1:64]: ciphertext; bit 1 is the MSB (DES numbering).
- key_in, input, [1:64]: DES key including parity bits 8, 16, ..., 64; parity bits are ignored and not checked.
- out_valid, output, 1: pt_out holds a result.
- out_ready, input, 1: downstream accepts pt_out.
- pt_out, output, [1:64]: plaintext, registered.
- busy, output, 1: high in ROUND and DONE.

Behaviour:
- Reset is sampled on the clk edge while rst_n=0. It sets state=IDLE, out_valid=0, pt_out=0, round counter=0, and L/R/C/D=0.
  - Reset mid-ROUND or mid-DONE aborts the block; no output is produced.
- in_ready = (state==IDLE) && rst_n. It is 0 while reset is asserted.
- States:
  - IDLE: in_valid && in_ready at an edge is the accept. On accept: {L,R} <= IP(ct_in); {C,D} <= PC1(key_in); rnd <= 1; go to ROUND.
  - ROUND, decrypt round i = rnd, 1..16:
    - Key rotation: for i=1, use C and D unrotated. For i in {2, 9, 16}, rotate C and D right by 1. For all other i, rotate right by 2.
    - Rotated C/D are written back each round.
    - Round key is K = PC2(Crot, Drot). Subkeys therefore run K16..K1.
    - f(R,K) = P(S1..S8(E(R) xor K)), where the 48-bit word is split MSB-first into 6-bit groups feeding S1..S8.
    - Update: L <= R; R <= L xor f(R,K).
    - At i=16, pt_out <= FP({R_new, L_new}), which is the swapped preoutput; out_valid <= 1; go to DONE.
    - Otherwise rnd <= rnd+1.
  - DONE: pt_out and out_valid hold stable until out_ready=1 at an edge. Then out_valid <= 0, state <= IDLE, and L/R/C/D are zeroized if ZEROIZE=1.
- Latency:
  - Accept on edge N; rounds execute on edges N+1..N+16.
  - out_valid is high after edge N+16.
  - If out_ready is held high, the earliest next accept is edge N+18, giving a throughput of one block per 18 cycles.
- in_valid while not in IDLE is ignored; inputs are not captured.
- ct_in/key_in changes after the accept edge have no effect on the block in flight.
- out_ready while out_valid=0 has no effect.
- Permutation tables IP, FP, E, P, PC1, PC2 and the rotation schedule are exactly per FIPS 46-3.
- The round datapath is purely combinational between registers; no multicycle paths.

Test Plan:
- Known-answer 1: key 133457799BBCDFF1, ct 85E813540F0AB405, out_ready=1 -> pt_out=0123456789ABCDEF. out_valid first high exactly 16 edges after accept, for one cycle. in_ready=1 the cycle after.
- Known-answer 2 plus parity-ignore: key 0E329232EA6D0D73, ct 0000000000000000 -> pt 8787878787878787. Repeat with key 0F339333EB6C0C72 (every byte's LSB flipped) -> identical pt.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid rises -> pt_out stable, in_ready=0, busy=1, and in_valid pulses are ignored. Release -> one transfer, then IDLE.
- Back-to-back: in_valid held high with two blocks (KA1 then KA2), out_ready=1 -> second accept exactly 2 edges after first out_valid rises. Outputs are correct and in order.
- Reset mid-operation: assert rst_n=0 for 1 cycle at round 7 -> out_valid=0, pt_out=0, and in_ready=1 the cycle after reset is released. Then a new KA1 block decrypts correctly.
- Zeroize: ZEROIZE=1 -> internal L/R/C/D read as 0 after DONE->IDLE. With ZEROIZE=0 they retain their values, and pt_out is correct in both builds.
